// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - packed-BCD adder, one digit per clock, LSD first, start/done handshake
// Optional non-BCD input detection on err: BCD_INVALID_CHECK_EN
module bcd_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [4*NDIG-1:0]   a_q, a_d;
    logic [4*NDIG-1:0]   b_q, b_d;
    logic [4*NDIG-1:0]   sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          a_dig, b_dig, s_dig;
    logic [4:0]          t;
    logic                c_next;

`ifdef BCD_INVALID_CHECK_EN
    logic                err_q, err_d;

    function automatic logic has_bad_digit(input logic [4*NDIG-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_INVALID_CHECK_EN
        err_d   = err_q;
`endif

        a_dig = a_q[int'(idx_q)*4 +: 4];
        b_dig = b_q[int'(idx_q)*4 +: 4];
        t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
        // Decimal correction: adding 6 modulo 16 skips the six unused codes.
        if (t > 5'd9) begin
            s_dig  = t[3:0] + 4'd6;
            c_next = 1'b1;
        end else begin
            s_dig  = t[3:0];
            c_next = 1'b0;
        end

        case (state_q)
            RUN: begin
                sum_d[int'(idx_q)*4 +: 4] = s_dig;
                carry_d = c_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NDIG - 1)) begin
                    cout_d  = c_next;
                    idx_d   = '0;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                    busy_d  = 1'b1;
`ifdef BCD_INVALID_CHECK_EN
                    err_d   = has_bad_digit(a) | has_bad_digit(b);
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_INVALID_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef BCD_INVALID_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed scoreboard bench for bcd_serial_adder (NDIG=4)
module tb_bcd_serial_adder;

    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [4*NDIG-1:0] a_i, b_i;
    logic              cin_i;
    logic [4*NDIG-1:0] sum;
    logic              cout, busy, done, err;

    typedef struct packed {
        logic [4*NDIG-1:0] sum;
        logic              cout;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a_i),
        .b    (b_i),
        .cin  (cin_i),
        .sum  (sum),
        .cout (cout),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [4*NDIG-1:0] x, input logic [4*NDIG-1:0] y);
`ifdef BCD_INVALID_CHECK_EN
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; leaves the bench at the negedge right after the accepting edge.
    task automatic accept(input logic [4*NDIG-1:0] x, input logic [4*NDIG-1:0] y, input logic c,
                          input logic [4*NDIG-1:0] esum, input logic ecout, input bit push);
        exp_t e;
        a_i = x; b_i = y; cin_i = c; start = 1'b1;
        if (push) begin
            e.sum  = esum;
            e.cout = ecout;
            e.err  = exp_err(x, y);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
    endtask

    // cnt is the number of edges since the accepting edge at the current negedge.
    task automatic wait_done(input string tag, input int cnt0);
        int   cnt;
        exp_t e;
        cnt = cnt0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'(done), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_latency"}, 32'(cnt), 32'(NDIG));
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_err"}, 32'(err), 32'(e.err));
        end
    endtask

    task automatic watch_no_done(input string tag, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check({tag, "_extra_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);

        accept(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b1);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_sum_cleared", 32'(sum), 32'd0);
        wait_done("basic", 0);
        @(negedge clk);
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_hold_sum", 32'(sum), 32'h6912);
        check("basic_idle_busy", 32'(busy), 32'd0);

        accept(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        wait_done("ripple", 0);
        @(negedge clk);
        check("ripple_hold_cout", 32'(cout), 32'd1);
        accept(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1);
        check("max_cout_cleared", 32'(cout), 32'd0);
        wait_done("max", 0);
        @(negedge clk);

        accept(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1);
        wait_done("cin", 0);
        accept(16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b", 0);
        @(negedge clk);

        accept(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b1);
        @(negedge clk);
        a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 2);
        watch_no_done("busy_start", NDIG + 3);

        accept(16'h4321, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        watch_no_done("midrst", NDIG + 3);

        accept(16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1);
        check("inv_err_accept", 32'(err), 32'(exp_err(16'h00A0, 16'h0001)));
        wait_done("inv", 0);
        @(negedge clk);
        check("inv_err_hold", 32'(err), 32'(exp_err(16'h00A0, 16'h0001)));

        accept(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b1);
        check("clean_err_accept", 32'(err), 32'd0);
        wait_done("clean", 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
